// File: rtl/vga_timing.sv
// vga_timing: VGA raster counters plus registered pin stage.
// Define VGA_TEST_PATTERN_EN to replace rgb_in with 8 colour bars.
module vga_timing #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rgb_in,
  output logic [9:0] xCoord,
  output logic [9:0] yCoord,
  output logic       pix_en,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic [2:0] vga_red,
  output logic [2:0] vga_green,
  output logic [1:0] vga_blue
);

  localparam int H_TOTAL =
    H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL =
    V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST =
    10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST =
    10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT =
    10'(H_ACTIVE);
  localparam logic [9:0] V_ACT =
    10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG =
    10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END =
    10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG =
    10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END =
    10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;
  logic [9:0]       h_cnt_q;
  logic [9:0]       h_cnt_d;
  logic [9:0]       v_cnt_q;
  logic [9:0]       v_cnt_d;
  logic             hsync_q;
  logic             hsync_d;
  logic             vsync_q;
  logic             vsync_d;
  logic             active_q;
  logic             active_d;
  logic [7:0]       col_q;
  logic [7:0]       col_d;

  logic             h_wrap;
  logic             v_wrap;
  logic             act_c;
  logic             hs_c;
  logic             vs_c;
  logic [7:0]       pix_col;

  assign pix_en = (div_cnt_q == DIV_LAST);
  assign h_wrap = (h_cnt_q == H_LAST);
  assign v_wrap = (v_cnt_q == V_LAST);

  assign frame_start =
    pix_en & h_wrap & v_wrap;

  assign act_c = (h_cnt_q < H_ACT) &&
                 (v_cnt_q < V_ACT);
  assign hs_c  = (h_cnt_q >= HS_BEG) &&
                 (h_cnt_q <  HS_END);
  assign vs_c  = (v_cnt_q >= VS_BEG) &&
                 (v_cnt_q <  VS_END);

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar;
  logic       unused_rgb;

  assign unused_rgb = ^rgb_in;
  // 80-pixel-wide bars; index bits pick B/G/R
  assign bar = 3'(h_cnt_q / 10'd80);
  assign pix_col = {{2{bar[2]}},
                    {3{bar[1]}},
                    {3{bar[0]}}};
`else
  assign pix_col = rgb_in;
`endif

  always_comb begin
    div_cnt_d = div_cnt_q + DIV_W'(1);
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    if (pix_en) begin
      div_cnt_d = '0;
      if (h_wrap) begin
        h_cnt_d = '0;
        if (v_wrap) begin
          v_cnt_d = '0;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  // Pin stage samples the pre-advance position,
  // so colour and sync share one pixel of delay.
  always_comb begin
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    active_d = active_q;
    col_d    = col_q;
    if (pix_en) begin
      hsync_d  = ~hs_c;
      vsync_d  = ~vs_c;
      active_d = act_c;
      col_d    = act_c ? pix_col : 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      active_q  <= 1'b0;
      col_q     <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      active_q  <= active_d;
      col_q     <= col_d;
    end
  end

  assign xCoord    = h_cnt_q;
  assign yCoord    = v_cnt_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign active    = active_q;
  assign vga_blue  = col_q[7:6];
  assign vga_green = col_q[5:3];
  assign vga_red   = col_q[2:0];

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: random-colour bench for vga_timing against a
// model derived from elapsed clocks since reset release.
module tb_vga_timing;

  localparam int CD = 4;
  localparam int HA = 640;
  localparam int HF = 16;
  localparam int HS = 96;
  localparam int HB = 48;
  localparam int VA = 4;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rgb_in;
  logic [9:0] xCoord;
  logic [9:0] yCoord;
  logic       pix_en;
  logic       frame_start;
  logic       hsync;
  logic       vsync;
  logic       active;
  logic [2:0] vga_red;
  logic [2:0] vga_green;
  logic [1:0] vga_blue;

  vga_timing #(
    .CLK_DIV(CD),
    .H_ACTIVE(HA), .H_FP(HF),
    .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF),
    .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rgb_in(rgb_in),
    .xCoord(xCoord),
    .yCoord(yCoord),
    .pix_en(pix_en),
    .frame_start(frame_start),
    .hsync(hsync),
    .vsync(vsync),
    .active(active),
    .vga_red(vga_red),
    .vga_green(vga_green),
    .vga_blue(vga_blue)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n;
  bit rnd_rgb;
  logic [7:0] rgb_lat;

  logic [9:0] e_x;
  logic [9:0] e_y;
  logic       e_pix;
  logic       e_fs;
  logic       e_hs;
  logic       e_vs;
  logic       e_act;
  logic [7:0] e_col;

  // Expected outputs after n rising edges since release
  function void model();
    int p;
    int q;
    int xp;
    int yp;
    int bar;
    p     = n / CD;
    e_x   = 10'(p % HT);
    e_y   = 10'((p / HT) % VT);
    e_pix = (n % CD) == CD - 1;
    e_fs  = e_pix && (p % HT) == HT - 1 &&
            ((p / HT) % VT) == VT - 1;
    if (p == 0) begin
      e_hs  = 1'b1;
      e_vs  = 1'b1;
      e_act = 1'b0;
      e_col = 8'd0;
    end else begin
      q     = p - 1;
      xp    = q % HT;
      yp    = (q / HT) % VT;
      e_hs  = !(xp >= HA + HF &&
                xp < HA + HF + HS);
      e_vs  = !(yp >= VA + VF &&
                yp < VA + VF + VS);
      e_act = xp < HA && yp < VA;
`ifdef VGA_TEST_PATTERN_EN
      bar   = xp / 80;
      e_col = {bar[2] ? 2'b11 : 2'b00,
               bar[1] ? 3'b111 : 3'b000,
               bar[0] ? 3'b111 : 3'b000};
`else
      bar   = 0;
      e_col = rgb_lat;
`endif
      if (!e_act) e_col = 8'd0;
    end
  endfunction

  task automatic step();
    @(negedge clk);
    if (rnd_rgb) rgb_in = 8'($urandom);
    if ((n % CD) == CD - 1) rgb_lat = rgb_in;
    @(posedge clk);
    n++;
    #1;
    model();
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    rgb_in  = 8'd0;
    rgb_lat = 8'd0;
    rnd_rgb = 1'b0;
    n       = 0;
    repeat (10) begin
      @(negedge clk);
      checks++;
      if ({xCoord, yCoord, pix_en,
           frame_start, hsync, vsync,
           active, vga_red, vga_green,
           vga_blue} !==
          {10'd0, 10'd0, 1'b0, 1'b0,
           1'b1, 1'b1, 1'b0, 3'd0,
           3'd0, 2'd0}) begin
        errors++;
        $display("FAIL reset_hold x=%0d y=%0d pe=%b hs=%b vs=%b act=%b",
                 xCoord, yCoord, pix_en,
                 hsync, vsync, active);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n     = 0;
    model();
    for (int k = 1; k <= CD; k++) begin
      step();
      checks++;
      if ({pix_en, xCoord} !==
          {k == CD - 1,
           (k == CD) ? 10'd1 : 10'd0})
      begin
        errors++;
        $display("FAIL first_pix edge=%0d got pe=%b x=%0d",
                 k, pix_en, xCoord);
      end
    end
  endtask

  task automatic test_hsync_lines();
    int falls[4];
    int nf = 0;
    int rise = -1;
    int x656 = -1;
    logic prev;
    rnd_rgb = 1'b1;
    prev = hsync;
    repeat (2 * CD * HT + 64) begin
      step();
      checks++;
      if ({xCoord, yCoord, hsync,
           pix_en} !==
          {e_x, e_y, e_hs, e_pix}) begin
        errors++;
        $display("FAIL hsync_line n=%0d got x=%0d hs=%b pe=%b exp x=%0d hs=%b pe=%b",
                 n, xCoord, hsync, pix_en,
                 e_x, e_hs, e_pix);
      end
      if (x656 < 0 && xCoord == 10'(HA + HF))
        x656 = n;
      if (prev && !hsync && nf < 4) begin
        falls[nf] = n;
        nf++;
      end
      if (!prev && hsync && rise < 0)
        rise = n;
      prev = hsync;
    end
    checks++;
    if (nf < 2 ||
        falls[1] - falls[0] != CD * HT ||
        rise - falls[0] != CD * HS ||
        falls[0] - x656 != CD) begin
      errors++;
      $display("FAIL hsync_period falls=%0d f0=%0d f1=%0d rise=%0d x656=%0d",
               nf, falls[0], falls[1],
               rise, x656);
    end
  endtask

  task automatic test_frames();
    int fs[2];
    int nfs = 0;
    int vfall = -1;
    int vrise = -1;
    int lstart = -1;
    int guard = 0;
    logic prev;
    rnd_rgb = 1'b0;
    rgb_in  = 8'b01111000;
    prev = vsync;
    while (nfs < 2 &&
           guard < 2 * CD * HT * VT + 1000)
    begin
      step();
      guard++;
      checks++;
      if ({yCoord, xCoord, vsync,
           frame_start, active, vga_blue,
           vga_green, vga_red} !==
          {e_y, e_x, e_vs, e_fs, e_act,
           e_col}) begin
        errors++;
        $display("FAIL frame n=%0d got y=%0d vs=%b fs=%b act=%b col=%h exp y=%0d vs=%b fs=%b act=%b col=%h",
                 n, yCoord, vsync,
                 frame_start, active,
                 {vga_blue, vga_green,
                  vga_red},
                 e_y, e_vs, e_fs, e_act,
                 e_col);
      end
      if (frame_start) begin
        fs[nfs] = n;
        nfs++;
      end
      if (lstart < 0 && xCoord == 10'd0 &&
          yCoord == 10'(VA + VF))
        lstart = n;
      if (prev && !vsync && vfall < 0)
        vfall = n;
      if (!prev && vsync && vfall >= 0 &&
          vrise < 0)
        vrise = n;
      prev = vsync;
    end
    checks++;
    if (nfs < 2 ||
        fs[1] - fs[0] != CD * HT * VT)
    begin
      errors++;
      $display("FAIL frame_period got_pulses=%0d f0=%0d f1=%0d",
               nfs, fs[0], fs[1]);
    end
    checks++;
    if (vfall < 0 || vrise < 0 ||
        vrise - vfall != CD * HT * VS ||
        vfall - lstart != CD) begin
      errors++;
      $display("FAIL vsync_window fall=%0d rise=%0d line=%0d",
               vfall, vrise, lstart);
    end
  endtask

  task automatic test_color();
    rnd_rgb = 1'b1;
    repeat (2 * CD * HT) begin
      step();
      checks++;
      if ({active, vga_blue, vga_green,
           vga_red, hsync, vsync} !==
          {e_act, e_col, e_hs, e_vs}) begin
        errors++;
        $display("FAIL color n=%0d got act=%b col=%h exp act=%b col=%h",
                 n, active,
                 {vga_blue, vga_green,
                  vga_red},
                 e_act, e_col);
      end
    end
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    int fall = -1;
    logic prev;
    while (!(xCoord == 10'd300 &&
             yCoord == 10'd2) &&
           guard < 4 * CD * HT) begin
      step();
      guard++;
    end
    checks++;
    if (xCoord !== 10'd300 ||
        yCoord !== 10'd2) begin
      errors++;
      $display("FAIL reach_mid got x=%0d y=%0d",
               xCoord, yCoord);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({xCoord, yCoord, pix_en,
         frame_start, hsync, vsync,
         active, vga_red, vga_green,
         vga_blue} !==
        {10'd0, 10'd0, 1'b0, 1'b0,
         1'b1, 1'b1, 1'b0, 3'd0,
         3'd0, 2'd0}) begin
      errors++;
      $display("FAIL async_reset x=%0d y=%0d hs=%b vs=%b act=%b col=%h",
               xCoord, yCoord, hsync,
               vsync, active,
               {vga_blue, vga_green,
                vga_red});
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n     = 0;
    model();
    prev = hsync;
    repeat (CD * HT) begin
      step();
      checks++;
      if ({xCoord, yCoord, hsync, vsync,
           pix_en} !==
          {e_x, e_y, e_hs, e_vs, e_pix})
      begin
        errors++;
        $display("FAIL restart n=%0d got x=%0d y=%0d hs=%b exp x=%0d y=%0d hs=%b",
                 n, xCoord, yCoord, hsync,
                 e_x, e_y, e_hs);
      end
      if (prev && !hsync && fall < 0)
        fall = n;
      prev = hsync;
    end
    checks++;
    if (fall != CD * (HA + HF + 1)) begin
      errors++;
      $display("FAIL restart_hsync got=%0d want=%0d",
               fall, CD * (HA + HF + 1));
    end
  endtask

  initial begin
    test_reset();
    test_hsync_lines();
    test_frames();
    test_color();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog n=%0d", n);
    $fatal(1, "timeout");
  end

endmodule
